// File: rtl/monkey_keyboard_decoder_pkg.sv
// Shared scan-code constants, prefix FSM states and key-table index types
// for the monkey keyboard decoder.
package monkey_kbd_pkg;

   localparam logic [7:0] SC_EXT   = 8'hE0;
   localparam logic [7:0] SC_BREAK = 8'hF0;
   localparam logic [7:0] SC_UP    = 8'h75;
   localparam logic [7:0] SC_DOWN  = 8'h72;
   localparam logic [7:0] SC_LEFT  = 8'h6B;
   localparam logic [7:0] SC_RIGHT = 8'h74;
   localparam logic [7:0] SC_W     = 8'h1D;
   localparam logic [7:0] SC_S     = 8'h1B;
   localparam logic [7:0] SC_A     = 8'h1C;
   localparam logic [7:0] SC_D     = 8'h23;

   typedef enum logic [1:0] {
      IDLE,
      EXT,
      BREAK,
      EXT_BREAK
   } prefix_state_e;

   typedef enum logic [1:0] {
      UP    = 2'd0,
      DOWN  = 2'd1,
      LEFT  = 2'd2,
      RIGHT = 2'd3
   } key_idx_e;

   typedef struct packed {
      logic     hit;
      key_idx_e idx;
   } key_hit_t;

   // Arrow keys only exist behind the E0 prefix; letters are plain codes.
   function automatic key_hit_t map_ext(input logic [7:0] code);
      key_hit_t r;
      r.hit = 1'b1;
      r.idx = UP;
      unique case (code)
         SC_UP:    r.idx = UP;
         SC_DOWN:  r.idx = DOWN;
         SC_LEFT:  r.idx = LEFT;
         SC_RIGHT: r.idx = RIGHT;
         default:  r.hit = 1'b0;
      endcase
      return r;
   endfunction

   function automatic key_hit_t map_plain(input logic [7:0] code);
      key_hit_t r;
      r.hit = 1'b1;
      r.idx = UP;
      unique case (code)
         SC_W:    r.idx = UP;
         SC_S:    r.idx = DOWN;
         SC_A:    r.idx = LEFT;
         SC_D:    r.idx = RIGHT;
         default: r.hit = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/monkey_keyboard_decoder_if.sv
// Bundle of PS/2 pins, frame strobe and decoded key outputs between the
// board-side driver (master) and the decoder (slave).
interface monkey_keyboard_decoder_if;

   logic       kbdClk;
   logic       kbdDat;
   logic       startOfFrame;
   logic       leftPressed;
   logic       rightPressed;
   logic       downPressed;
   logic       upPressed;
   logic [7:0] keyCode;
   logic       keyValid;
   logic       frameError;

   modport master (
      output kbdClk, kbdDat, startOfFrame,
      input  leftPressed, rightPressed, downPressed, upPressed,
      input  keyCode, keyValid, frameError
   );

   modport slave (
      input  kbdClk, kbdDat, startOfFrame,
      output leftPressed, rightPressed, downPressed, upPressed,
      output keyCode, keyValid, frameError
   );

endinterface

// File: rtl/monkey_keyboard_decoder_ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: pin synchronisers, falling-edge detect,
// 11-bit deserialiser with start/parity/stop check and a mid-frame timeout.
module ps2_frame_rx #(
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       kbd_clk_raw,
   input  logic       kbd_dat_raw,
   output logic [7:0] rx_byte,
   output logic       byte_valid,
   output logic       byte_err
);

   localparam int IDLE_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_CYCLES - 1);

   logic [1:0]        clk_sync_q, clk_sync_d;
   logic [1:0]        dat_sync_q, dat_sync_d;
   logic              clk_prev_q, clk_prev_d;
   logic [3:0]        bit_cnt_q, bit_cnt_d;
   logic [9:0]        shift_q, shift_d;
   logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
   logic [7:0]        byte_q, byte_d;
   logic              valid_q, valid_d;
   logic              err_q, err_d;
   logic              fall;
   logic              din;
   logic              frame_ok;

   assign fall = clk_prev_q & ~clk_sync_q[1];
   assign din  = dat_sync_q[1];

   // Bits 0..9 sit in shift_q by the time bit 10 arrives; the stop bit is checked live.
   assign frame_ok = ~shift_q[0] & din & (^shift_q[9:1]);

   always_comb begin
      clk_sync_d = {clk_sync_q[0], kbd_clk_raw};
      dat_sync_d = {dat_sync_q[0], kbd_dat_raw};
      clk_prev_d = clk_sync_q[1];
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      idle_cnt_d = idle_cnt_q;
      byte_d     = byte_q;
      valid_d    = 1'b0;
      err_d      = 1'b0;

      if (fall) begin
         idle_cnt_d = '0;
         if (bit_cnt_q == 4'd10) begin
            bit_cnt_d = '0;
            if (frame_ok) begin
               valid_d = 1'b1;
               byte_d  = shift_q[8:1];
            end else begin
               err_d = 1'b1;
            end
         end else begin
            shift_d   = {din, shift_q[9:1]};
            bit_cnt_d = bit_cnt_q + 4'd1;
         end
      end else begin
         if (idle_cnt_q != IDLE_MAX) begin
            idle_cnt_d = idle_cnt_q + IDLE_W'(1);
         end
         if ((bit_cnt_q != 4'd0) && (idle_cnt_q == IDLE_MAX)) begin
            bit_cnt_d = '0;
         end
      end
   end

   // Synchronisers reset high so leaving reset never looks like a falling edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         clk_sync_q <= 2'b11;
         dat_sync_q <= 2'b11;
         clk_prev_q <= 1'b1;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         idle_cnt_q <= '0;
         byte_q     <= '0;
         valid_q    <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         clk_sync_q <= clk_sync_d;
         dat_sync_q <= dat_sync_d;
         clk_prev_q <= clk_prev_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         idle_cnt_q <= idle_cnt_d;
         byte_q     <= byte_d;
         valid_q    <= valid_d;
         err_q      <= err_d;
      end
   end

   assign rx_byte    = byte_q;
   assign byte_valid = valid_q;
   assign byte_err   = err_q;

endmodule

// File: rtl/monkey_keyboard_decoder.sv
// Monkey keyboard front end: E0/F0 prefix FSM and arrow/WASD key table.
// Define UP_ONE_SHOT_EN to make upPressed a one-jump-per-press pulse.
module monkey_keyboard_decoder
   import monkey_kbd_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic                      clk,
   input  logic                      reset,
   monkey_keyboard_decoder_if.slave  kbd
);

   logic          [7:0] rx_byte;
   logic                byte_valid;
   logic                byte_err;
   prefix_state_e       state_q, state_d;
   logic          [3:0] arrow_q, arrow_d;
   logic          [3:0] letter_q, letter_d;
   key_hit_t            ext_hit;
   key_hit_t            plain_hit;
   logic                up_make;

   ps2_frame_rx #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_rx (
      .clk         (clk),
      .reset       (reset),
      .kbd_clk_raw (kbd.kbdClk),
      .kbd_dat_raw (kbd.kbdDat),
      .rx_byte     (rx_byte),
      .byte_valid  (byte_valid),
      .byte_err    (byte_err)
   );

   assign ext_hit   = map_ext(rx_byte);
   assign plain_hit = map_plain(rx_byte);

   // Arrow and letter bits are tracked separately so releasing one keeps the other held.
   always_comb begin
      state_d  = state_q;
      arrow_d  = arrow_q;
      letter_d = letter_q;
      up_make  = 1'b0;

      if (byte_err) begin
         state_d = IDLE;
      end else if (byte_valid) begin
         unique case (state_q)
            IDLE: begin
               if (rx_byte == SC_EXT) begin
                  state_d = EXT;
               end else if (rx_byte == SC_BREAK) begin
                  state_d = BREAK;
               end else if (plain_hit.hit) begin
                  letter_d[plain_hit.idx] = 1'b1;
                  up_make = (plain_hit.idx == UP);
               end
            end
            EXT: begin
               if (rx_byte == SC_BREAK) begin
                  state_d = EXT_BREAK;
               end else if (rx_byte == SC_EXT) begin
                  state_d = EXT;
               end else begin
                  state_d = IDLE;
                  if (ext_hit.hit) begin
                     arrow_d[ext_hit.idx] = 1'b1;
                     up_make = (ext_hit.idx == UP);
                  end
               end
            end
            BREAK: begin
               if (rx_byte == SC_EXT) begin
                  state_d = EXT_BREAK;
               end else if (rx_byte == SC_BREAK) begin
                  state_d = BREAK;
               end else begin
                  state_d = IDLE;
                  if (plain_hit.hit) begin
                     letter_d[plain_hit.idx] = 1'b0;
                  end
               end
            end
            EXT_BREAK: begin
               if ((rx_byte != SC_EXT) && (rx_byte != SC_BREAK)) begin
                  state_d = IDLE;
                  if (ext_hit.hit) begin
                     arrow_d[ext_hit.idx] = 1'b0;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         arrow_q  <= '0;
         letter_q <= '0;
      end else begin
         state_q  <= state_d;
         arrow_q  <= arrow_d;
         letter_q <= letter_d;
      end
   end

   assign kbd.leftPressed  = arrow_q[LEFT]  | letter_q[LEFT];
   assign kbd.rightPressed = arrow_q[RIGHT] | letter_q[RIGHT];
   assign kbd.downPressed  = arrow_q[DOWN]  | letter_q[DOWN];
   assign kbd.keyCode      = rx_byte;
   assign kbd.keyValid     = byte_valid;
   assign kbd.frameError   = byte_err;

`ifdef UP_ONE_SHOT_EN
   logic up_shot_q, up_shot_d;

   // Only a make from the released state arms the shot, so typematic repeats never re-fire.
   always_comb begin
      up_shot_d = up_shot_q;
      if (up_make && !(arrow_q[UP] | letter_q[UP])) begin
         up_shot_d = 1'b1;
      end else if (kbd.startOfFrame) begin
         up_shot_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         up_shot_q <= 1'b0;
      end else begin
         up_shot_q <= up_shot_d;
      end
   end

   assign kbd.upPressed = up_shot_q;
`else
   logic unused_one_shot;

   assign unused_one_shot = kbd.startOfFrame ^ up_make;
   assign kbd.upPressed   = arrow_q[UP] | letter_q[UP];
`endif

endmodule

// File: doc/monkey_keyboard_decoder.md
Name: monkey_keyboard_decoder

Overview:
- PS/2 keyboard front end that produces the level key signals consumed by the monkey movement/collision logic: leftPressed, rightPressed, downPressed, upPressed.
- Deserialises PS/2 device-to-host frames and tracks the E0/F0 make/break prefixes.
- Keeps a pressed/released state for the arrow keys and the WASD keys.
- Sits between the board PS/2 pins and the game-object movement modules.

Parameters:
- TIMEOUT_CYCLES, 100000, idle clk cycles mid-frame before the partial frame is discarded (2 ms at 50 MHz).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- kbdClk  in  1  raw PS/2 clock pin, asynchronous
- kbdDat  in  1  raw PS/2 data pin, asynchronous
- startOfFrame  in  1  one-cycle pulse per video frame; used only with UP_ONE_SHOT_EN
- leftPressed  out  1  left arrow or A held
- rightPressed  out  1  right arrow or D held
- downPressed  out  1  down arrow or S held
- upPressed  out  1  up arrow or W held (one-shot under UP_ONE_SHOT_EN)
- keyCode  out  8  last valid received byte
- keyValid  out  1  one-cycle pulse when keyCode updates
- frameError  out  1  one-cycle pulse on a rejected frame

Behaviour:
- Reset values: all outputs 0, keyCode 8'h00, FSM IDLE, bit counter 0, key table cleared.
- Synchronisation: two-flop synchroniser on kbdClk and kbdDat. A falling edge is detected as synced-previous=1 and synced-now=0.
- Sampling: on each detected falling edge, shift in the synced data bit.
- Frame format, bits 0..10: start=0, D0..D7 LSB first, odd parity, stop=1.
- On bit 10: accept the frame only if start==0, stop==1 and XOR(D7..D0,parity)==1. Then pulse keyValid and load keyCode.
- Otherwise pulse frameError; key table and keyCode are unchanged.
- In both cases the bit counter returns to 0.
- Timeout: the idle counter clears on every falling edge. If the bit counter is nonzero and the idle counter reaches TIMEOUT_CYCLES-1, the bit counter clears. No pulse is issued.
- Latency: keyValid is high on the 3rd rising clk edge after the synchronised stop-bit falling edge is sampled. Key outputs update one edge later. Total is 4–5 clk from the pin edge.
- Prefix FSM (advances on keyValid only):
  - IDLE: E0→EXT; F0→BREAK; any other byte = plain make, stay IDLE.
  - EXT: F0→EXT_BREAK; E0→EXT; other = extended make →IDLE.
  - BREAK: E0→EXT_BREAK; F0→BREAK; other = plain break →IDLE.
  - EXT_BREAK: E0/F0 stay; other = extended break →IDLE.
  - frameError in any state →IDLE.
- Key map:
  - extended: 75 up, 72 down, 6B left, 74 right
  - plain: 1D W, 1B S, 1C A, 23 D
  - make sets the bit, break clears it; unmapped codes (AA, FA, EE, …) are ignored.
- Typematic repeat makes are idempotent.
- Each output is the OR of its arrow and letter bit. Simultaneous left and right are both reported; priority belongs to the consumer.
- Reset mid-frame: partial frame discarded, key table cleared immediately, asynchronously.

Optional Feature:
- Macro: UP_ONE_SHOT_EN.
- Defined:
  - upPressed is set by an up/W make arriving while the up key state was released.
  - It stays high through the next startOfFrame pulse and clears on the cycle after that pulse.
  - Held-key repeats and continued holding do not re-arm it; only a break followed by a new make re-arms.
  - This gives exactly one jump per press.
- Undefined: upPressed is a plain level and startOfFrame is ignored.

Decomposition:
- Package monkey_kbd_pkg holds:
  - scan-code constants: SC_EXT=8'hE0, SC_BREAK=8'hF0, the eight key codes
  - the FSM state enum: IDLE, EXT, BREAK, EXT_BREAK
  - key-index typedef: UP, DOWN, LEFT, RIGHT
- Sub-module ps2_frame_rx: synchroniser, edge detect, shift register, parity/stop check, timeout. It outputs byte, byteValid and byteErr.
- The top level keeps the FSM, key table and one-shot.

Test Plan:
- Send E0,75, then E0,F0,75 → upPressed rises within 5 clk of the last stop edge, then returns to 0; keyValid pulses 2 then 3 times.
- Send 1C, then E0,6B, then F0,1C → leftPressed stays 1 until the E0,F0,6B break; 1C release alone keeps it 1 (arrow still held).
- Send frame 6B with even parity → frameError pulses once, keyValid stays 0, FSM returns to IDLE (next 23 sets rightPressed).
- Send 5 bits, idle TIMEOUT_CYCLES clk, then full frame 23 → rightPressed=1, no frameError.
- Assert reset after 4 bits of a frame with downPressed=1 → all outputs 0 immediately; a following valid E0,72 sets downPressed.
- With UP_ONE_SHOT_EN, send 1D and repeats 1D,1D → upPressed high until cycle after first startOfFrame, then 0 despite repeats; F0,1D,1D re-fires.
